// File: rtl/segscan_ctrl.sv
// segscan_ctrl: multiplexed seven-segment scan controller with a double-buffered display, a per-slot
// anti-ghosting blank and a frame-boundary commit. Define SEGSCAN_DIMMING_EN to add iBright PWM dimming.
module segscan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [4*NUM_DIGITS-1:0] iValue,
    input  logic [NUM_DIGITS-1:0]   iDot,
    input  logic [NUM_DIGITS-1:0]   iDigitEn,
    input  logic                    iLoad,
`ifdef SEGSCAN_DIMMING_EN
    input  logic [3:0]              iBright,
`endif
    output logic [NUM_DIGITS-1:0]   oAnode,
    output logic [7:0]              oSeg,
    output logic                    oFrame,
    output logic                    oPending
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0]            SEG_OFF  = {8{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] dispVal, pendVal;
    logic [NUM_DIGITS-1:0]   dispDot, pendDot, dispEn, pendEn;
    logic                    frameDly;

    logic                  lastCnt, frameEdge, blank, anodeOn, curDot, curEn;
    logic [3:0]            curVal;
    logic [NUM_DIGITS-1:0] anodeHi;
    logic [7:0]            segHi;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;  4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;  4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;  4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;  4'hE: decode = 7'h79;  default: decode = 7'h71;
        endcase
    endfunction

`ifdef SEGSCAN_DIMMING_EN
    logic [3:0] pwm;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) pwm <= '0;
        else         pwm <= pwm + 4'd1;
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path leaves one unassigned (no latch).
        lastCnt   = (cnt == CNT_LAST);
        frameEdge = lastCnt && (idx == IDX_LAST);
        curVal    = dispVal[4*idx +: 4];
        curDot    = dispDot[idx];
        curEn     = dispEn[idx];
        blank     = (int'(cnt) < BLANK_CYCLES) || !curEn;
`ifdef SEGSCAN_DIMMING_EN
        anodeOn   = !blank && ((iBright == 4'hF) || (pwm < iBright));
`else
        anodeOn   = !blank;
`endif
        anodeHi   = anodeOn ? (NUM_DIGITS'(1) << idx) : '0;
        segHi     = blank ? 8'h00 : {curDot, decode(curVal)};
    end

    // Slot timing: cnt walks one digit slot, idx steps through the digits.
    always_ff @(posedge iClk or negedge iRst_n) begin
        // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
        if (!iRst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (lastCnt) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: a load on the frame edge wins over the commit and defers it one frame.
    always_ff @(posedge iClk or negedge iRst_n) begin
        // NOTE: these buffers are a few flops, so they are reset; a real RAM array would not be.
        if (!iRst_n) begin
            pendVal  <= '0;
            pendDot  <= '0;
            pendEn   <= '0;
            dispVal  <= '0;
            dispDot  <= '0;
            dispEn   <= '0;
            oPending <= 1'b0;
        end else if (iLoad) begin
            pendVal  <= iValue;
            pendDot  <= iDot;
            pendEn   <= iDigitEn;
            oPending <= 1'b1;
        end else if (frameEdge && oPending) begin
            dispVal  <= pendVal;
            dispDot  <= pendDot;
            dispEn   <= pendEn;
            oPending <= 1'b0;
        end
    end

    // Registered pins; oFrame needs two stages to line up with the first output cycle of slot 0.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oAnode   <= AN_OFF;
            oSeg     <= SEG_OFF;
            frameDly <= 1'b0;
            oFrame   <= 1'b0;
        end else begin
            oAnode   <= anodeHi ^ AN_OFF;
            oSeg     <= segHi ^ SEG_OFF;
            frameDly <= frameEdge;
            oFrame   <= frameDly;
        end
    end

endmodule

// File: tb/tb_segscan_ctrl.sv
// tb_segscan_ctrl: scoreboard bench for segscan_ctrl (4 digits, 8-cycle slots, 2 blank cycles, active-low).
module tb_segscan_ctrl;

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] seg;
        logic       frame;
    } exp_t;

    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  e;
    } load_t;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [15:0] iValue;
    logic [3:0]  iDot, iDigitEn;
    logic        iLoad;
    logic [3:0]  oAnode;
    logic [7:0]  oSeg;
    logic        oFrame, oPending;

    int testCount = 0;
    int failCount = 0;

    exp_t  sbQ[$];
    load_t ldQ[$];

    // Bench's own view of the display and pending buffers.
    logic [15:0] mVal, mPendVal;
    logic [3:0]  mDot, mEn, mPendDot, mPendEn;
    logic        mPend;

    logic [6:0] decTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    segscan_ctrl #(
        .NUM_DIGITS    (4),
        .CLK_DIV       (8),
        .BLANK_CYCLES  (2),
        .AN_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iValue  (iValue),
        .iDot    (iDot),
        .iDigitEn(iDigitEn),
        .iLoad   (iLoad),
        .oAnode  (oAnode),
        .oSeg    (oSeg),
        .oFrame  (oFrame),
        .oPending(oPending)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        testCount++;
        if (got !== want) begin
            failCount++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic resetModel();
        mVal = '0; mDot = '0; mEn = '0;
        mPendVal = '0; mPendDot = '0; mPendEn = '0;
        mPend = 1'b0;
    endtask

    task automatic schedLoad(input int at, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        load_t l;
        l.at = at; l.v = v; l.d = d; l.e = e;
        ldQ.push_back(l);
    endtask

    // One frame of expected pin values from the display contents the bench holds right now.
    task automatic pushFrame(input bit firstAfterReset);
        exp_t x;
        logic [3:0] nib;
        bit blank;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                nib   = mVal[4*s +: 4];
                blank = (c < 2) || !mEn[s];
                x.anode = blank ? 4'hF : ~(4'b0001 << s);
                x.seg   = blank ? 8'hFF : ~{mDot[s], decTab[nib]};
                x.frame = (s == 0) && (c == 0) && !firstAfterReset;
                sbQ.push_back(x);
            end
        end
    endtask

    // Runs nEdges clock edges of one output window; called at a falling edge, returns at one.
    task automatic runFrame(input bit firstAfterReset, input int nEdges);
        exp_t  x;
        load_t l;
        bit    ld;
        pushFrame(firstAfterReset);
        for (int j = 1; j <= nEdges; j++) begin
            ld = (ldQ.size() > 0) && (ldQ[0].at == j);
            if (ld) begin
                l = ldQ.pop_front();
                iValue = l.v; iDot = l.d; iDigitEn = l.e;
            end
            iLoad = ld;
            @(posedge iClk);
            if (ld) begin
                mPendVal = l.v; mPendDot = l.d; mPendEn = l.e;
                mPend = 1'b1;
            end else if (j == 32 && mPend) begin
                mVal = mPendVal; mDot = mPendDot; mEn = mPendEn;
                mPend = 1'b0;
            end
            @(negedge iClk);
            iLoad = 1'b0;
            x = sbQ.pop_front();
            check("anode", 32'(oAnode), 32'(x.anode));
            check("seg", 32'(oSeg), 32'(x.seg));
            check("frame", 32'(oFrame), 32'(x.frame));
            check("pending", 32'(oPending), 32'(mPend));
        end
    endtask

    initial begin
        iRst_n = 1'b0; iLoad = 1'b0; iValue = '0; iDot = '0; iDigitEn = '0;
        resetModel();
        repeat (3) @(negedge iClk);
        check("rst_anode", 32'(oAnode), 32'h0000000F);
        check("rst_seg", 32'(oSeg), 32'h000000FF);
        check("rst_pending", 32'(oPending), 32'h0);
        check("rst_frame", 32'(oFrame), 32'h0);
        iRst_n = 1'b1;

        // Window 0: blank display, load at edge 3, committed at the first frame edge.
        schedLoad(3, 16'hF80A, 4'b0001, 4'hF);
        runFrame(1'b1, 32);
        // Window 1: F80A shown; load a digit-2-blanked version.
        schedLoad(10, 16'hF80A, 4'b0001, 4'b1011);
        runFrame(1'b0, 32);
        // Window 2: slot 2 blanked; 2222 is overwritten by 1111 loaded on the commit edge.
        schedLoad(5, 16'h2222, 4'b0000, 4'hF);
        schedLoad(32, 16'h1111, 4'b0000, 4'hF);
        runFrame(1'b0, 32);
        // Window 3: commit deferred, display unchanged, 1111 committed at its end.
        runFrame(1'b0, 32);
        // Window 4: 1111 shown; pending 3333, then asynchronous reset inside slot 2.
        schedLoad(3, 16'h3333, 4'b1111, 4'hF);
        runFrame(1'b0, 20);
        #2 iRst_n = 1'b0;
        #1;
        check("async_anode", 32'(oAnode), 32'h0000000F);
        check("async_seg", 32'(oSeg), 32'h000000FF);
        check("async_pending", 32'(oPending), 32'h0);
        check("async_frame", 32'(oFrame), 32'h0);
        sbQ.delete();
        ldQ.delete();
        resetModel();
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        // Pending 3333 was discarded: two frames with nothing displayed and no pending flag.
        runFrame(1'b1, 32);
        runFrame(1'b0, 32);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
